multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. In each state it drives the register-file write-address/write-data selects, ALU controls, SRAM enables and PC update. It sits beside the register preparer and ALU and owns every control input of that datapath.

## Interface
- No parameters.
- `clk`  in  1  core clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `run`  in  1  start enable, sampled only in S_IF
- `instruction`  in  32  latched IR from datapath, valid from S_ID onward
- `alu_zero`  in  1  ALU result == 0
- `inst_sram_en`  out  1  instruction fetch request
- `ir_wen`  out  1  latch instruction SRAM rdata into IR
- `data_sram_en`  out  1  data SRAM access
- `data_sram_wen`  out  4  byte write enables
- `reg_wen`  out  1  register-file write
- `control_reg_waddr`  out  2  00 rd, 01 rt, 10 r31
- `control_reg_wdata`  out  2  00 ALU, 01 dmem, 10 {imm,16'd0}
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll
- `alu_src_a`  out  1  0 rs, 1 PC
- `alu_src_b`  out  2  00 rt, 01 sign-extended imm, 10 constant 8
- `pc_wen`  out  1  PC update, marks instruction retire
- `pc_src`  out  2  00 PC+4, 01 branch target, 10 jump target
- `illegal_inst`  out  1  one-cycle pulse on unsupported opcode/funct
- `state`  out  3  current state, debug

## Operation
- States are S_IF=0, S_IW=1, S_ID=2, S_EX=3, S_MEM=4, S_MW=5 and S_WB=6. Codes 7 are illegal and go to S_IF.
- S_IF:
  - run=1: assert inst_sram_en, go to S_IW.
  - run=0: stay in S_IF, all outputs 0.
- S_IW: assert ir_wen (SRAM has 1-cycle latency), go to S_ID.
- S_ID: decode `instruction[31:26]` and, for R-type, funct `[5:0]`.
  - j: pc_wen=1, pc_src=10, go to S_IF.
  - lui: go to S_WB.
  - Unsupported: illegal_inst=1, pc_wen=1, pc_src=00, go to S_IF.
  - All others: go to S_EX.
- S_EX: alu_op and alu_src_a/b are set by the instruction class.
  - R-type addu/subu/and/or/slt/sll: src_b=00, go to S_WB.
  - addiu: add, src_b=01, go to S_WB.
  - lw/sw: add, src_b=01, go to S_MEM.
  - beq/bne: sub, src_b=00, pc_wen=1. pc_src=01 if taken (beq: alu_zero=1; bne: alu_zero=0), else 00. Go to S_IF.
  - jal: add, src_a=1, src_b=10 (link = PC+8), go to S_WB.
- S_MEM: data_sram_en=1, ALU controls held from S_EX.
  - sw: data_sram_wen=4'hF, pc_wen=1, pc_src=00, go to S_IF.
  - lw: data_sram_wen=0, go to S_MW.
- S_MW: hold the lw address, go to S_WB.
- S_WB: reg_wen=1, pc_wen=1, then go to S_IF.
  - R-type: waddr=00, wdata=00.
  - addiu: waddr=01, wdata=00.
  - lw: waddr=01, wdata=01.
  - lui: waddr=01, wdata=10.
  - jal: waddr=10, wdata=00, pc_src=10.
  - All others: pc_src=00.
- Outputs are combinational from state and IR. Controls not listed for a state are 0.

## Timing
- Reset (async assert, sync release): state=S_IF and every output 0. Reset mid-instruction abandons it with no pc_wen or reg_wen.
- Cycles per instruction:
  - j: 3
  - beq/bne, lui: 4
  - ALU ops, addiu, jal, sw: 5
  - lw: 7
- Exactly one pc_wen per instruction, in its final cycle. reg_wen and pc_wen never assert in the same cycle except in S_WB.
- Data SRAM lw read data is valid in S_MW and consumed in S_WB.
- illegal_inst pulse coincides with pc_wen in S_ID.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined: adds outputs `perf_cycles[31:0]` and `perf_retired[31:0]`, both reset to 0.
  - perf_cycles increments every cycle unless state=S_IF with run=0.
  - perf_retired increments on each pc_wen.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent, and FSM behaviour is identical.

## Test plan
- Reset with run=0 for 5 cycles: state=0, all outputs 0. Raise run: inst_sram_en=1 next cycle.
- addu 0x00851821: ID→EX (alu_op=0) → WB with reg_wen=1, waddr=00, wdata=00, pc_wen=1, pc_src=00. Total 5 cycles.
- lw 0x8C880004 then sw 0xAC880004: lw takes 7 cycles, with WB waddr=01 and wdata=01. sw takes 5 cycles, with data_sram_wen=4'hF in S_MEM and no reg_wen.
- beq 0x10850003:
  - alu_zero=1 in S_EX: pc_src=01.
  - alu_zero=0: pc_src=00.
  - Both take 4 cycles.
- jal 0x0C000010: EX src_a=1, src_b=10; WB waddr=10, pc_src=10. Instruction 0xFC000000: illegal_inst pulse in S_ID with pc_wen, back to S_IF.
- resetn asserted in S_MW of lw: next state S_IF, no reg_wen. With PERF_EN, counters reset to 0, and 10 ALU instructions give perf_retired=10, perf_cycles=50.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath control bundle between multicycle_ctrl and the MIPS datapath
interface multicycle_ctrl_if;
    logic        run;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        inst_sram_en;
    logic        ir_wen;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic        reg_wen;
    logic [1:0]  control_reg_waddr;
    logic [1:0]  control_reg_wdata;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_wen;
    logic [1:0]  pc_src;
    logic        illegal_inst;

    modport master (
        input  run, instruction, alu_zero,
        output inst_sram_en, ir_wen, data_sram_en, data_sram_wen, reg_wen,
               control_reg_waddr, control_reg_wdata, alu_op, alu_src_a, alu_src_b,
               pc_wen, pc_src, illegal_inst
    );

    modport slave (
        output run, instruction, alu_zero,
        input  inst_sram_en, ir_wen, data_sram_en, data_sram_wen, reg_wen,
               control_reg_waddr, control_reg_wdata, alu_op, alu_src_a, alu_src_b,
               pc_wen, pc_src, illegal_inst
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM (IF/IW/ID/EX/MEM/MW/WB)
// Optional MULTICYCLE_CTRL_PERF_EN adds perf_cycles / perf_retired counters.
module multicycle_ctrl (
    input  logic               clk,
    input  logic               resetn,
    multicycle_ctrl_if.master  bus,
    output logic [2:0]         state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_retired
`endif
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_IW  = 3'd1,
        S_ID  = 3'd2,
        S_EX  = 3'd3,
        S_MEM = 3'd4,
        S_MW  = 3'd5,
        S_WB  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_ADDIU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_LUI, C_BAD
    } iclass_t;

    state_t      state_q, state_d;
    iclass_t     iclass;
    logic [3:0]  r_op;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];
    assign state  = state_q;

    always_comb begin
        iclass = C_BAD;
        r_op   = 4'd0;
        case (opcode)
            6'h00: begin
                iclass = C_RALU;
                case (funct)
                    6'h21:   r_op = 4'd0;
                    6'h23:   r_op = 4'd1;
                    6'h24:   r_op = 4'd2;
                    6'h25:   r_op = 4'd3;
                    6'h2A:   r_op = 4'd4;
                    6'h00:   r_op = 4'd5;
                    default: iclass = C_BAD;
                endcase
            end
            6'h02:   iclass = C_J;
            6'h03:   iclass = C_JAL;
            6'h04:   iclass = C_BEQ;
            6'h05:   iclass = C_BNE;
            6'h09:   iclass = C_ADDIU;
            6'h0F:   iclass = C_LUI;
            6'h23:   iclass = C_LW;
            6'h2B:   iclass = C_SW;
            default: iclass = C_BAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d               = S_IF;
        bus.inst_sram_en      = 1'b0;
        bus.ir_wen            = 1'b0;
        bus.data_sram_en      = 1'b0;
        bus.data_sram_wen     = 4'h0;
        bus.reg_wen           = 1'b0;
        bus.control_reg_waddr = 2'b00;
        bus.control_reg_wdata = 2'b00;
        bus.alu_op            = 4'd0;
        bus.alu_src_a         = 1'b0;
        bus.alu_src_b         = 2'b00;
        bus.pc_wen            = 1'b0;
        bus.pc_src            = 2'b00;
        bus.illegal_inst      = 1'b0;
        case (state_q)
            S_IF: begin
                if (bus.run) begin
                    bus.inst_sram_en = 1'b1;
                    state_d          = S_IW;
                end else begin
                    state_d = S_IF;
                end
            end
            S_IW: begin
                bus.ir_wen = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                case (iclass)
                    C_J: begin
                        bus.pc_wen = 1'b1;
                        bus.pc_src = 2'b10;
                        state_d    = S_IF;
                    end
                    C_LUI: state_d = S_WB;
                    C_BAD: begin
                        bus.illegal_inst = 1'b1;
                        bus.pc_wen       = 1'b1;
                        state_d          = S_IF;
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (iclass)
                    C_RALU: begin
                        bus.alu_op = r_op;
                        state_d    = S_WB;
                    end
                    C_ADDIU: begin
                        bus.alu_src_b = 2'b01;
                        state_d       = S_WB;
                    end
                    C_LW, C_SW: begin
                        bus.alu_src_b = 2'b01;
                        state_d       = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        bus.alu_op = 4'd1;
                        bus.pc_wen = 1'b1;
                        // Taken when the equality test matches the branch sense.
                        if ((iclass == C_BEQ) == bus.alu_zero) bus.pc_src = 2'b01;
                        state_d = S_IF;
                    end
                    C_JAL: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'b10;
                        state_d       = S_WB;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                bus.data_sram_en = 1'b1;
                bus.alu_src_b    = 2'b01;
                if (iclass == C_SW) begin
                    bus.data_sram_wen = 4'hF;
                    bus.pc_wen        = 1'b1;
                    state_d           = S_IF;
                end else begin
                    state_d = S_MW;
                end
            end
            S_MW: begin
                // Keep the effective address on the bus while load data settles.
                bus.alu_src_b = 2'b01;
                state_d       = S_WB;
            end
            S_WB: begin
                bus.reg_wen = 1'b1;
                bus.pc_wen  = 1'b1;
                case (iclass)
                    C_ADDIU: bus.control_reg_waddr = 2'b01;
                    C_LW: begin
                        bus.control_reg_waddr = 2'b01;
                        bus.control_reg_wdata = 2'b01;
                    end
                    C_LUI: begin
                        bus.control_reg_waddr = 2'b01;
                        bus.control_reg_wdata = 2'b10;
                    end
                    C_JAL: begin
                        bus.control_reg_waddr = 2'b10;
                        bus.pc_src            = 2'b10;
                    end
                    default: ;
                endcase
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cycles  <= 32'd0;
            perf_retired <= 32'd0;
        end else begin
            if (!(state_q == S_IF && !bus.run)) perf_cycles <= perf_cycles + 32'd1;
            if (bus.pc_wen) perf_retired <= perf_retired + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master),
        .state  (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired)
`endif
    );

    logic [22:0] all_out;
    assign all_out = {bus.inst_sram_en, bus.ir_wen, bus.data_sram_en, bus.data_sram_wen,
                      bus.reg_wen, bus.control_reg_waddr, bus.control_reg_wdata, bus.alu_op,
                      bus.alu_src_a, bus.alu_src_b, bus.pc_wen, bus.pc_src, bus.illegal_inst};

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         cycles;
        int         regwen_n;
        logic [1:0] wa, wd, psrc;
        bit         ill, ill_ok, memw, overlap, timeout;
        int         aop;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] end_state;
    } obs_t;

    typedef struct {
        int         cycles;
        bit         rw;
        logic [1:0] wa, wd, psrc;
        bit         ill, memw;
        int         aop;
        logic       srca;
        logic [1:0] srcb;
    } exp_t;

    // Reference: what one instruction should do end-to-end, from the ISA-level rules.
    function automatic exp_t model(input logic [31:0] ins, input bit z);
        exp_t e;
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        e = '{default: 0};
        e.aop = -1;
        case (op)
            6'd0: begin
                case (fn)
                    6'd33: e.aop = 0;
                    6'd35: e.aop = 1;
                    6'd36: e.aop = 2;
                    6'd37: e.aop = 3;
                    6'd42: e.aop = 4;
                    6'd0:  e.aop = 5;
                    default: e.ill = 1;
                endcase
                if (!e.ill) begin e.cycles = 5; e.rw = 1; end
            end
            6'd9:  begin e.cycles = 5; e.rw = 1; e.wa = 1; e.aop = 0; e.srcb = 1; end
            6'd35: begin e.cycles = 7; e.rw = 1; e.wa = 1; e.wd = 1; e.aop = 0; e.srcb = 1; end
            6'd43: begin e.cycles = 5; e.memw = 1; e.aop = 0; e.srcb = 1; end
            6'd4:  begin e.cycles = 4; e.aop = 1; e.psrc = z ? 2'd1 : 2'd0; end
            6'd5:  begin e.cycles = 4; e.aop = 1; e.psrc = z ? 2'd0 : 2'd1; end
            6'd2:  begin e.cycles = 3; e.psrc = 2; end
            6'd3:  begin e.cycles = 5; e.rw = 1; e.wa = 2; e.psrc = 2; e.aop = 0; e.srca = 1; e.srcb = 2; end
            6'd15: begin e.cycles = 4; e.rw = 1; e.wa = 1; e.wd = 2; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.cycles = 3; e.psrc = 0; end
        return e;
    endfunction

    // Drive one instruction from S_IF and record what the controller did until pc_wen.
    task automatic run_inst(input logic [31:0] ins, input bit z, output obs_t o);
        o = '{default: 0};
        o.aop = -1;
        bus.instruction = ins;
        bus.alu_zero    = z;
        bus.run         = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (state == 3'd3) begin
                o.aop = int'(bus.alu_op); o.srca = bus.alu_src_a; o.srcb = bus.alu_src_b;
            end
            if (bus.reg_wen) begin
                o.regwen_n++; o.wa = bus.control_reg_waddr; o.wd = bus.control_reg_wdata;
            end
            if (bus.reg_wen && bus.pc_wen && state != 3'd6) o.overlap = 1;
            if (bus.illegal_inst) begin o.ill = 1; o.ill_ok = bus.pc_wen && state == 3'd2; end
            if (bus.data_sram_en && bus.data_sram_wen == 4'hF) o.memw = 1;
            if (bus.pc_wen) begin
                o.cycles = c;
                o.psrc   = bus.pc_src;
                @(negedge clk);
                bus.run = 1'b0;
                #1;
                o.end_state = state;
                return;
            end
            @(negedge clk);
        end
        o.timeout = 1;
        bus.run = 1'b0;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0;
        bus.instruction = 32'h0;
        bus.alu_zero = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || all_out !== 23'd0)
            $display("FAIL reset_hold: state=%0d outs=%h want state=0 outs=0", state, all_out);
        else passes++;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || all_out !== 23'd0)
                $display("FAIL idle_%0d: state=%0d outs=%h want state=0 outs=0", i, state, all_out);
            else passes++;
        end
        bus.run = 1'b1;
        #1;
        checks++;
        if (bus.inst_sram_en !== 1'b1)
            $display("FAIL run_fetch: inst_sram_en=%b want 1", bus.inst_sram_en);
        else passes++;
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || bus.ir_wen !== 1'b1)
            $display("FAIL iw_state: state=%0d ir_wen=%b want 1/1", state, bus.ir_wen);
        else passes++;
        do_reset();
    endtask

    task automatic test_instructions();
        logic [31:0] dir_ins [8] = '{32'h00851821, 32'h8C880004, 32'hAC880004, 32'h10850003,
                                     32'h10850003, 32'h0C000010, 32'hFC000000, 32'h3C011234};
        bit          dir_z   [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic [5:0]  ops     [9] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd15, 6'd35, 6'd43};
        logic [5:0]  fns     [7] = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd42, 6'd0, 6'd63};
        logic [5:0]  bad_ops [4] = '{6'h3F, 6'h01, 6'h20, 6'h10};
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            bit z;
            obs_t o;
            exp_t e;
            string nm;
            if (n < 8) begin
                ins = dir_ins[n]; z = dir_z[n];
            end else begin
                ins = $urandom;
                z = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) ins[31:26] = bad_ops[$urandom_range(0, 3)];
                else ins[31:26] = ops[$urandom_range(0, 8)];
                if (ins[31:26] == 6'd0) ins[5:0] = fns[$urandom_range(0, 6)];
            end
            e = model(ins, z);
            run_inst(ins, z, o);
            nm = $sformatf("%08h_z%0d", ins, z);
            checks++;
            if (o.timeout) begin
                $display("FAIL %s timeout: no pc_wen within 12 cycles", nm);
                do_reset();
                continue;
            end
            if (o.cycles !== e.cycles) $display("FAIL %s cycles: got %0d want %0d", nm, o.cycles, e.cycles);
            else passes++;
            checks++;
            if (o.regwen_n !== int'(e.rw)) $display("FAIL %s reg_wen_count: got %0d want %0d", nm, o.regwen_n, e.rw);
            else passes++;
            checks++;
            if (e.rw && {o.wa, o.wd} !== {e.wa, e.wd})
                $display("FAIL %s waddr_wdata: got %b/%b want %b/%b", nm, o.wa, o.wd, e.wa, e.wd);
            else passes++;
            checks++;
            if (o.psrc !== e.psrc) $display("FAIL %s pc_src: got %b want %b", nm, o.psrc, e.psrc);
            else passes++;
            checks++;
            if (o.ill !== e.ill || (e.ill && !o.ill_ok))
                $display("FAIL %s illegal: got %b with_pcwen_in_id=%b want %b", nm, o.ill, o.ill_ok, e.ill);
            else passes++;
            checks++;
            if (o.memw !== e.memw) $display("FAIL %s store_wen: got %b want %b", nm, o.memw, e.memw);
            else passes++;
            checks++;
            if (o.aop !== e.aop || (e.aop >= 0 && {o.srca, o.srcb} !== {e.srca, e.srcb}))
                $display("FAIL %s ex_alu: got op=%0d a=%b b=%b want op=%0d a=%b b=%b",
                         nm, o.aop, o.srca, o.srcb, e.aop, e.srca, e.srcb);
            else passes++;
            checks++;
            if (o.overlap || o.end_state !== 3'd0)
                $display("FAIL %s retire: overlap=%b end_state=%0d want 0/0", nm, o.overlap, o.end_state);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        bit seen_rw;
        bit reached;
        seen_rw = 0;
        reached = 0;
        bus.instruction = 32'h8C880004;
        bus.alu_zero = 1'b0;
        bus.run = 1'b1;
        for (int c = 0; c < 10 && !reached; c++) begin
            @(negedge clk);
            bus.run = 1'b0;
            if (state == 3'd5) reached = 1;
        end
        checks++;
        if (!reached) $display("FAIL mid_reach_mw: state=%0d want 5 within 10 cycles", state);
        else passes++;
        resetn = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || all_out !== 23'd0)
            $display("FAIL mid_reset: state=%0d outs=%h want 0/0", state, all_out);
        else passes++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.reg_wen || bus.pc_wen) seen_rw = 1;
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        if (bus.reg_wen || bus.pc_wen) seen_rw = 1;
        checks++;
        if (seen_rw || state !== 3'd0)
            $display("FAIL mid_abandon: wen_seen=%b state=%0d want 0/0", seen_rw, state);
        else passes++;
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd0 || perf_retired !== 32'd0)
            $display("FAIL perf_reset: cycles=%0d retired=%0d want 0/0", perf_cycles, perf_retired);
        else passes++;
`endif
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf();
        logic [5:0] fns [6] = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd42, 6'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ins;
            obs_t o;
            ins = $urandom;
            ins[31:26] = 6'd0;
            ins[5:0] = fns[$urandom_range(0, 5)];
            run_inst(ins, 1'($urandom_range(0, 1)), o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (perf_retired !== 32'd10) $display("FAIL perf_retired: got %0d want 10", perf_retired);
        else passes++;
        checks++;
        if (perf_cycles !== 32'd50) $display("FAIL perf_cycles: got %0d want 50", perf_cycles);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_instructions();
        test_reset_mid();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
